// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, width helpers and read-mode enum for sync_fifo_param
//
// Contents:
//   DEF_DATA_W, DEF_DEPTH  default word width and entry count
//   ptr_width(depth)       pointer width, $clog2(depth)
//   count_width(depth)     occupancy width, one bit wider so DEPTH itself fits
//   read_mode_e / READ_MODE  REG_OUT (registered dout) or FWFT; FWFT when
//                          FIFO_FWFT_EN is defined
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic {
        REG_OUT = 1'b0,
        FWFT    = 1'b1
    } read_mode_e;

`ifdef FIFO_FWFT_EN
    localparam read_mode_e READ_MODE = FWFT;
`else
    localparam read_mode_e READ_MODE = REG_OUT;
`endif

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - simple dual-port DATA_W x DEPTH storage array for sync_fifo_param
//
// Optional feature macro: FIFO_FWFT_EN (asynchronous read port when defined).
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-low reset; clears only the registered read data
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable (registered mode only)
//   raddr  in   read address
//   rdata  out  read data: registered (1-cycle latency) by default,
//               combinational mem[raddr] under FIFO_FWFT_EN
module fifo_mem_2p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Storage is deliberately not reset so it can map onto RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; reset and read enable play no part.
    assign rdata = mem[raddr];

    logic unused_ok;
    assign unused_ok = &{1'b0, rst, re};
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with level flags, count and error pulses
//
// Optional feature macro: FIFO_FWFT_EN (first-word-fall-through dout, 0 read latency).
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-low reset
//   wr            in   write request
//   rd            in   read request (pop acknowledge in FWFT mode)
//   din           in   write data
//   dout          out  read data
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  current occupancy
//   overflow      out  one-cycle pulse after a write while full
//   underflow     out  one-cycle pulse after a read while empty
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,     // power of two, >= 4
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr,
    input  logic                          rd,
    input  logic [DATA_W-1:0]             din,
    output logic [DATA_W-1:0]             dout,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_ok;
    logic          rd_ok;

    // Flags decode only the registered count, so they never glitch mid-cycle.
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // Acceptance looks at this cycle's flags only: a same-cycle read does not
    // make room for a write at full, nor does a write feed a read at empty.
    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr & full;
            underflow <= rd & empty;
            if (wr_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_ok) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Reset wins over a write in the same cycle, so the array is not touched.
    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok & rst),
        .waddr (wptr),
        .wdata (din),
        .re    (rd_ok),
        .raddr (rptr),
        .rdata (dout)
    );

    a_count_range: assert property (@(posedge clk) disable iff (!rst) count <= FULL_CNT);
    a_flag_excl:   assert property (@(posedge clk) disable iff (!rst) !(full && empty));

endmodule
